// File: rtl/dtcm_port_arbiter.sv
// rtl/dtcm_port_arbiter.sv - DTCM SRAM port sharing between core data port and external master
// Core has per-cycle priority; ext wins once it has been denied STARVE_LIMIT cycles in a row.
module dtcm_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_mem_read,
  input  logic          core_mem_write,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ext_valid,
  output logic          ext_ready,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_rsp_valid,
  output logic [DW-1:0] ext_rsp_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       ext_rd_pend;
  logic       core_act, ext_force, grant_ext, grant_core;

  // Requests are masked by rst_n so every output is quiet while reset is held.
  assign core_act   = rst_n & (core_mem_read | core_mem_write) & (state == IDLE);
  assign ext_force  = (wait_cnt == LIMIT);
  assign grant_ext  = rst_n & ext_valid & (~core_act | ext_force);
  assign grant_core = core_act & ~grant_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      ext_rd_pend <= 1'b0;
    end else begin
      state       <= state_nxt;
      ext_rd_pend <= grant_ext & ~ext_we;
      if (!ext_valid || grant_ext)
        wait_cnt <= 4'd0;
      else if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_stall = 1'b0;
    core_rdata = '0;
    case (state)
      IDLE: begin
        if (core_act) begin
          if (core_mem_read) begin
            core_stall = 1'b1;
            if (grant_core) state_nxt = RD_WAIT;
          end else begin
            core_stall = grant_ext;
          end
        end
      end
      RD_WAIT: begin
        core_rdata = mem_rdata;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_cs    = grant_core | grant_ext;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_ext) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (grant_core) begin
      // A simultaneous read and write from the core is treated as a read.
      mem_we    = ~core_mem_read;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  assign ext_ready     = grant_ext;
  assign ext_rsp_valid = ext_rd_pend;
  assign ext_rsp_rdata = ext_rd_pend ? mem_rdata : '0;

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// tb/tb_dtcm_port_arbiter.sv - directed vector bench for dtcm_port_arbiter with a behavioural SRAM
module tb_dtcm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_mem_read, core_mem_write;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_valid, ext_ready, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_rsp_valid;
  logic [31:0] ext_rsp_rdata;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[7:0]];
    end
  end

  dtcm_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [31:0] caddr, cwdata;
    logic        ev, ewe;
    logic [31:0] eaddr, ewdata;
    logic        x_stall, x_ready, x_cs, x_we;
    logic [31:0] x_addr, x_wdata, x_crdata;
    logic        x_rspv;
    logic [31:0] x_rsp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic rd, input logic wr, input logic [31:0] ca,
                     input logic [31:0] cw, input logic ev, input logic ewe, input logic [31:0] ea,
                     input logic [31:0] ew, input logic s, input logic r, input logic cs,
                     input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] crd, input logic rv, input logic [31:0] rsp);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.caddr = ca; v.cwdata = cw;
    v.ev = ev; v.ewe = ewe; v.eaddr = ea; v.ewdata = ew;
    v.x_stall = s; v.x_ready = r; v.x_cs = cs; v.x_we = we; v.x_addr = a; v.x_wdata = wd;
    v.x_crdata = crd; v.x_rspv = rv; v.x_rsp = rsp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] ca, input logic [31:0] cw,
                       input logic ev, input logic ewe, input logic [31:0] ea, input logic [31:0] ew);
    core_mem_read = rd; core_mem_write = wr; core_addr = ca; core_wdata = cw;
    ext_valid = ev; ext_we = ewe; ext_addr = ea; ext_wdata = ew;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_stall"}, 32'(core_stall), 32'd0);
    chk({n, "_ready"}, 32'(ext_ready), 32'd0);
    chk({n, "_rspv"},  32'(ext_rsp_valid), 32'd0);
    chk({n, "_cs"},    32'(mem_cs), 32'd0);
    chk({n, "_crdata"}, core_rdata, 32'd0);
  endtask

  initial begin
    // name               rd wr caddr  cwdata         ev ewe eaddr  ewdata        st rdy cs we addr   wdata          crdata         rv rsp
    add("st10",          0, 1, 32'h10, 32'hA5A5_0001, 0, 0, 32'h00, 32'h0,        0, 0, 1, 1, 32'h10, 32'hA5A5_0001, 32'h0,         0, 32'h0);
    add("ld10",          1, 0, 32'h10, 32'h0,         0, 0, 32'h00, 32'h0,        1, 0, 1, 0, 32'h10, 32'h0,         32'h0,         0, 32'h0);
    add("ld10_wait",     1, 0, 32'h10, 32'h0,         0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'hA5A5_0001, 0, 32'h0);
    add("ext_wr20",      0, 0, 32'h00, 32'h0,         1, 1, 32'h20, 32'h1234_5678, 0, 1, 1, 1, 32'h20, 32'h1234_5678, 32'h0,        0, 32'h0);
    add("ext_rd20",      0, 0, 32'h00, 32'h0,         1, 0, 32'h20, 32'h0,        0, 1, 1, 0, 32'h20, 32'h0,         32'h0,         0, 32'h0);
    add("ext_rsp20",     0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'h0,         1, 32'h1234_5678);
    for (int k = 0; k < 4; k++)
      add($sformatf("starve%0d", k), 0, 1, 32'h40 + 32'(4*k), 32'hD000_0000 + 32'(k), 1, 1, 32'h30, 32'hCAFE_0000,
          0, 0, 1, 1, 32'h40 + 32'(4*k), 32'hD000_0000 + 32'(k), 32'h0, 0, 32'h0);
    add("force",         0, 1, 32'h50, 32'hD000_0050, 1, 1, 32'h30, 32'hCAFE_0000, 1, 1, 1, 1, 32'h30, 32'hCAFE_0000, 32'h0,        0, 32'h0);
    add("st50_after",    0, 1, 32'h50, 32'hD000_0050, 0, 1, 32'h30, 32'hCAFE_0000, 0, 0, 1, 1, 32'h50, 32'hD000_0050, 32'h0,        0, 32'h0);
    add("cnt_cleared",   0, 1, 32'h54, 32'hD000_0054, 1, 1, 32'h30, 32'hCAFE_0001, 0, 0, 1, 1, 32'h54, 32'hD000_0054, 32'h0,        0, 32'h0);
    add("ext_core_idle", 0, 0, 32'h00, 32'h0,         1, 1, 32'h30, 32'hCAFE_0001, 0, 1, 1, 1, 32'h30, 32'hCAFE_0001, 32'h0,        0, 32'h0);
    add("ld_vs_ext",     1, 0, 32'h10, 32'h0,         1, 0, 32'h20, 32'h0,        1, 0, 1, 0, 32'h10, 32'h0,         32'h0,         0, 32'h0);
    add("rdwait_ext",    1, 0, 32'h10, 32'h0,         1, 0, 32'h20, 32'h0,        0, 1, 1, 0, 32'h20, 32'h0,         32'hA5A5_0001, 0, 32'h0);
    add("ext_rsp_b",     0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'h0,         1, 32'h1234_5678);
    add("rd_wins",       1, 1, 32'h10, 32'hFFFF_FFFF, 0, 0, 32'h00, 32'h0,        1, 0, 1, 0, 32'h10, 32'h0,         32'h0,         0, 32'h0);
    add("rd_wins_wait",  1, 1, 32'h10, 32'hFFFF_FFFF, 0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'hA5A5_0001, 0, 32'h0);
    add("ld30",          1, 0, 32'h30, 32'h0,         0, 0, 32'h00, 32'h0,        1, 0, 1, 0, 32'h30, 32'h0,         32'h0,         0, 32'h0);
    add("ld30_wait",     1, 0, 32'h30, 32'h0,         0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'hCAFE_0001, 0, 32'h0);
    add("ld44",          1, 0, 32'h44, 32'h0,         0, 0, 32'h00, 32'h0,        1, 0, 1, 0, 32'h44, 32'h0,         32'h0,         0, 32'h0);
    add("ld44_wait",     1, 0, 32'h44, 32'h0,         0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,         32'hD000_0001, 0, 32'h0);

    rst_n = 1'b0;
    drive(1, 1, 32'h10, 32'h1, 1, 0, 32'h20, 32'h2);
    #12;
    chk_quiet("reset");
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].caddr, vecs[i].cwdata,
            vecs[i].ev, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewdata);
      @(negedge clk);
      chk({vecs[i].name, "_stall"},  32'(core_stall),    32'(vecs[i].x_stall));
      chk({vecs[i].name, "_ready"},  32'(ext_ready),     32'(vecs[i].x_ready));
      chk({vecs[i].name, "_cs"},     32'(mem_cs),        32'(vecs[i].x_cs));
      chk({vecs[i].name, "_we"},     32'(mem_we),        32'(vecs[i].x_we));
      chk({vecs[i].name, "_addr"},   mem_addr,           vecs[i].x_addr);
      // Write data is don't-care while the port is doing a read.
      if (vecs[i].x_we || !vecs[i].x_cs)
        chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].x_wdata);
      chk({vecs[i].name, "_crdata"}, core_rdata,         vecs[i].x_crdata);
      chk({vecs[i].name, "_rspv"},   32'(ext_rsp_valid), 32'(vecs[i].x_rspv));
      chk({vecs[i].name, "_rsp"},    ext_rsp_rdata,      vecs[i].x_rsp);
    end

    // Reset while the core load sits in RD_WAIT.
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_rd_issue_stall", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    #1;
    chk_quiet("rst_in_rdwait");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_quiet("rst_rdwait_after");

    // Reset right after an ext read handshake drops the response.
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    @(negedge clk);
    chk("rst_ext_hs_ready", 32'(ext_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_ext_rspv_low", 32'(ext_rsp_valid), 32'd0);
    chk("rst_ext_rsp_low", ext_rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ext_rspv_after", 32'(ext_rsp_valid), 32'd0);
    chk("rst_ext_cs_after", 32'(mem_cs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
